// File: rtl/led_sequencer.sv
// Bus-mapped LED pattern sequencer: patterns are queued through a small FIFO and
// each one is shown on ledr for holdReg+1 cycles; the last one stays up until replaced.
module led_sequencer #(
    parameter int unsigned          DBITS         = 32,
    parameter logic [DBITS-1:0]     LED_NAMESPACE = 32'hF000_0004,
    parameter logic [DBITS-1:0]     LEDCTRL_ADDR  = 32'hF000_0104,
    parameter logic [DBITS-1:0]     LEDHOLD_ADDR  = 32'hF000_0204,
    parameter int unsigned          FIFO_DEPTH    = 4,
    parameter logic [DBITS-1:0]     HOLD_RESET    = 32'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrtEn,
    input  logic [DBITS-1:0] address,
    inout  wire  [DBITS-1:0] dbus,
    output logic [9:0]       ledr
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [9:0]       ledr_q, ledr_d;
    logic [DBITS-1:0] hold_cnt_q, hold_cnt_d;
    logic [DBITS-1:0] hold_reg_q, hold_reg_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [9:0]       mem_q [FIFO_DEPTH];

    logic push, wr_ctrl, wr_hold, rd_data, rd_ctrl, rd_hold, rd_any;
    logic empty, full, pop, push_ok, ovf_set;
    logic [31:0]      count_ext;
    logic [2:0]       cnt_field;
    logic [DBITS-1:0] rd_word;

    assign push    = wrtEn  && (address == LED_NAMESPACE);
    assign wr_ctrl = wrtEn  && (address == LEDCTRL_ADDR);
    assign wr_hold = wrtEn  && (address == LEDHOLD_ADDR);
    assign rd_data = !wrtEn && (address == LED_NAMESPACE);
    assign rd_ctrl = !wrtEn && (address == LEDCTRL_ADDR);
    assign rd_hold = !wrtEn && (address == LEDHOLD_ADDR);
    assign rd_any  = rd_data || rd_ctrl || rd_hold;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));

    // Display FSM: decides when the head of the FIFO is popped onto ledr.
    always_comb begin
        state_d    = state_q;
        ledr_d     = ledr_q;
        hold_cnt_d = hold_cnt_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    ledr_d     = mem_q[rd_ptr_q];
                    hold_cnt_d = '0;
                    state_d    = SHOW;
                end
            end
            SHOW: begin
                if (hold_cnt_q == hold_reg_q) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        ledr_d     = mem_q[rd_ptr_q];
                        hold_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + DBITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A push into a full FIFO still fits when the head leaves in the same cycle.
    always_comb begin
        push_ok    = push && (!full || pop);
        ovf_set    = push && full && !pop;
        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
        overflow_d = overflow_q;
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (wr_ctrl && !dbus[2]) begin
            overflow_d = 1'b0;
        end
        hold_reg_d = wr_hold ? dbus : hold_reg_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ledr_q     <= 10'd0;
            hold_cnt_q <= '0;
            hold_reg_q <= HOLD_RESET;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ledr_q     <= ledr_d;
            hold_cnt_q <= hold_cnt_d;
            hold_reg_q <= hold_reg_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wr_ptr_q] <= dbus[9:0];
        end
    end

    assign count_ext = 32'(count_q);
    assign cnt_field = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];

    always_comb begin
        rd_word = '0;
        if (rd_data) begin
            rd_word[9:0] = ledr_q;
        end else if (rd_ctrl) begin
            rd_word[6:4] = cnt_field;
            rd_word[2]   = overflow_q;
            rd_word[1]   = full;
            rd_word[0]   = empty;
        end else if (rd_hold) begin
            rd_word = hold_reg_q;
        end
    end

    assign dbus = rd_any ? rd_word : {DBITS{1'bz}};
    assign ledr = ledr_q;

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): DBITS, 32, bus width; LED_NAMESPACE, 32'hF000_0004, pattern push/readback address; LEDCTRL_ADDR, 32'hF000_0104, status/control address; LEDHOLD_ADDR, 32'hF000_0204, hold-count register address; FIFO_DEPTH, 4, pattern queue entries (power of 2); HOLD_RESET, 32'd0, hold-count value after reset.
REQ-002 clk  input  1  sole clock; every register SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 wrtEn  input  1  bus write strobe; low means the current address is a read.
REQ-005 address  input  DBITS  bus address, full-width compare.
REQ-006 dbus  inout  DBITS  shared data bus; driven only during a read of one of this block's addresses, otherwise all-Z.
REQ-007 ledr  output  10  LED pattern, driven from a register.

Function
REQ-008 Decodes SHALL be: push = wrtEn & address==LED_NAMESPACE; wrCtrl = wrtEn & address==LEDCTRL_ADDR; wrHold = wrtEn & address==LEDHOLD_ADDR; rdData, rdCtrl, rdHold = !wrtEn & the matching address.
REQ-009 A push SHALL enqueue dbus[9:0]; dbus[DBITS-1:10] SHALL be ignored.
REQ-010 FIFO: FIFO_DEPTH entries, wrap-around read/write pointers, fill count 0..FIFO_DEPTH; empty = (count==0), full = (count==FIFO_DEPTH).
REQ-011 FSM states: IDLE and SHOW.
REQ-012 IDLE with FIFO non-empty: pop the head into ledr, set holdCnt to 0, go to SHOW in the same edge.
REQ-013 A push into an empty FIFO in IDLE at edge N SHALL appear on ledr at edge N+1.
REQ-014 In SHOW, holdCnt SHALL increment by 1 per cycle.
REQ-015 When holdCnt == holdReg in SHOW: if the FIFO is non-empty, pop the next pattern into ledr, set holdCnt to 0 and stay in SHOW; otherwise go to IDLE.
REQ-016 Every pattern SHALL be displayed for exactly holdReg+1 cycles, except the last one, which remains on ledr indefinitely.
REQ-017 holdCnt SHALL be DBITS wide and compared for equality.
REQ-018 A write of holdReg during SHOW SHALL take effect in the next comparison.
REQ-019 Push with FIFO full and a pop in the same cycle SHALL be accepted, leaving count unchanged.
REQ-020 Push with FIFO full and no pop in the same cycle SHALL be dropped and SHALL set overflow (sticky).
REQ-021 Push with FIFO not full and a simultaneous pop SHALL leave count unchanged.
REQ-022 wrCtrl with dbus[2]==0 SHALL clear overflow; wrCtrl with dbus[2]==1 SHALL have no effect.
REQ-023 If an overflow-setting push and a clear occur in the same cycle, set SHALL win. This can only arise with distinct addresses, so it is unreachable on one bus; the priority is specified for completeness.
REQ-024 wrHold SHALL load holdReg with dbus[DBITS-1:0].
REQ-025 Read data SHALL be: rdData = {22'd0, ledr}; rdCtrl = {DBITS-7 zeros, count[2:0] at bits [6:4], 0 at bit 3, overflow at bit 2, full at bit 1, empty at bit 0}; rdHold = holdReg.
REQ-026 If FIFO_DEPTH > 7, the count field SHALL saturate at 7.
REQ-027 Reads SHALL have no side effects.

Reset
REQ-028 Reset SHALL force ledr=10'd0, FIFO empty with both pointers at 0, overflow=0, holdCnt=0, holdReg=HOLD_RESET and state=IDLE.
REQ-029 Reset asserted during SHOW SHALL abort the display and discard all queued patterns.
REQ-030 Reset SHALL take priority over any bus access in the same cycle.
REQ-031 While reset is asserted, dbus SHALL follow the read decode like any other cycle, returning reset values.

Verification
REQ-032 Reset, then rdCtrl -> 32'h0000_0001; rdHold -> HOLD_RESET; ledr = 0.
REQ-033 holdReg=3; push 10'h155 at edge N -> ledr=10'h155 from edge N+1 onward indefinitely; status empty=1 after edge N+1.
REQ-034 holdReg=3; back-to-back pushes 10'h001, 10'h002, 10'h004 -> each pattern held exactly 4 cycles in order, then 10'h004 remains and the FSM reaches IDLE.
REQ-035 holdReg=100; 6 consecutive pushes -> first popped immediately, next 4 fill the FIFO, 6th dropped; rdCtrl = 32'h0000_0046 (count=4, overflow=1, full=1); wrCtrl 0 -> overflow clears, rdCtrl = 32'h0000_0042.
REQ-036 FIFO full, push on the exact cycle the hold expires -> push accepted, overflow stays 0, count stays 4.
REQ-037 Reset asserted mid-SHOW with 3 patterns queued -> next cycle ledr=0, rdCtrl = 32'h0000_0001; with no bus read active, dbus = Z.
